// File: rtl/sshr_iter_if.sv
// Request/result bundle for the iterative arithmetic right shifter.
// The master drives an operand and shift amount; the slave returns a result with a done strobe.
interface sshr_iter_if #(
    parameter int DATAWIDTH = 8,
    parameter int SHWIDTH   = 3
);
    logic                 Start;
    logic [DATAWIDTH-1:0] A;
    logic [SHWIDTH-1:0]   ShAmt;
    logic [DATAWIDTH-1:0] D;
    logic                 Busy;
    logic                 Done;

    modport master (
        output Start, A, ShAmt,
        input  D, Busy, Done
    );

    modport slave (
        input  Start, A, ShAmt,
        output D, Busy, Done
    );
endinterface

// File: rtl/sshr_iter.sv
// Signed arithmetic shift-right, one bit position per clock. The result is
// registered and presented with a one-cycle Done strobe.
module sshr_iter #(
    parameter int DATAWIDTH = 8,
    parameter int SHWIDTH   = 3
) (
    input  logic       Clk,
    input  logic       Rst,
    sshr_iter_if.slave bus
);
    localparam int          CW    = (DATAWIDTH > 2) ? $clog2(DATAWIDTH) : 1;
    localparam logic [31:0] MAXSH = 32'(DATAWIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               stateQ, stateD;
    logic [DATAWIDTH-1:0] workQ, workD;
    logic [DATAWIDTH-1:0] dQ, dD;
    logic [CW-1:0]        countQ, countD;
    logic [31:0]          shAmtWide;

    assign shAmtWide = 32'(bus.ShAmt);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            stateQ <= IDLE;
            workQ  <= '0;
            countQ <= '0;
            dQ     <= '0;
        end else begin
            stateQ <= stateD;
            workQ  <= workD;
            countQ <= countD;
            dQ     <= dD;
        end
    end

    // D loads on the edge that enters DONE, so the result is valid while Done is high.
    always_comb begin
        stateD = stateQ;
        workD  = workQ;
        countD = countQ;
        dD     = dQ;
        case (stateQ)
            IDLE: begin
                if (bus.Start) begin
                    workD  = bus.A;
                    countD = (shAmtWide >= MAXSH) ? MAXSH[CW-1:0] : shAmtWide[CW-1:0];
                    if (countD == '0) begin
                        stateD = DONE;
                        dD     = bus.A;
                    end else begin
                        stateD = SHIFT;
                    end
                end
            end
            SHIFT: begin
                workD  = {workQ[DATAWIDTH-1], workQ[DATAWIDTH-1:1]};
                countD = countQ - CW'(1);
                if (countQ == CW'(1)) begin
                    stateD = DONE;
                    dD     = workD;
                end
            end
            DONE: begin
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    assign bus.D    = dQ;
    assign bus.Busy = (stateQ != IDLE);
    assign bus.Done = (stateQ == DONE);
endmodule

// File: doc/sshr_iter.md
# sshr_iter

Sequential signed arithmetic shift-right unit for the datapath component library. It accepts a signed operand and shift amount on a one-cycle start pulse and shifts one bit position per clock. It then presents the registered result with a one-cycle done strobe. It sits between operand registers and downstream REG/COMP stages in multicycle schedules, where a full combinational barrel shift would set the critical path.

## Interface
- DATAWIDTH, 8, operand/result width in bits (≥2)
- SHWIDTH, 3, width of shift-amount input (≥1)

- Clk  input  1  rising-edge clock
- Rst  input  1  synchronous, active-low reset (sampled on Clk rising edge; 0 = reset)
- Start  input  1  request pulse; sampled only in IDLE
- A  input  DATAWIDTH  signed operand, captured when Start accepted
- ShAmt  input  SHWIDTH  unsigned shift amount, captured when Start accepted
- D  output  DATAWIDTH  signed result, registered, held until next completion
- Busy  output  1  high while an operation is in progress (SHIFT or DONE state)
- Done  output  1  one-cycle strobe; D valid in the same cycle

## Operation
- State machine: IDLE, SHIFT, DONE.
- IDLE, Start=1:
  - capture A into the work register;
  - load count = min(ShAmt, DATAWIDTH-1);
  - go to SHIFT if count≠0, else go directly to DONE.
- IDLE, Start=0: stay in IDLE; no register changes.
- SHIFT, each cycle:
  - work ← {work[MSB], work[MSB:1]} (sign-extending shift by 1);
  - count ← count-1;
  - when count reaches 0 after this update, go to DONE.
- DONE: D ← work, Done=1 for exactly this cycle, then return to IDLE.
- Clamp: ShAmt ≥ DATAWIDTH-1 yields all sign bits (0…0 or 1…1). Latency is capped at DATAWIDTH cycles.
- Start is ignored in SHIFT and DONE. It is not queued, and A/ShAmt changes are ignored.
- D changes only in DONE (and on reset). Between operations it holds the last result.
- No overflow case exists: an arithmetic right shift never exceeds the range of the input.

## Timing
- Reset values: state=IDLE, D=0, Busy=0, Done=0, work=0, count=0.
- Reset has priority over all other activity. Asserting Rst=0 mid-operation aborts the operation with no Done and leaves D=0 after the reset cycle.
- Let c = min(ShAmt, DATAWIDTH-1) and let Start be accepted at clock edge t (sampled in IDLE):
  - Busy=1 from cycle t+1 through the cycle in which Done=1;
  - SHIFT occupies c cycles;
  - Done=1 and D valid in cycle t+1+c; Busy falls the next cycle.
- Earliest next Start acceptance is the edge ending the first IDLE cycle after Done. Initiation interval is c+2 cycles.
- Done and Busy are registered outputs (decoded from state registers), with no combinational path from inputs.

## Test plan
- DATAWIDTH=8, SHWIDTH=4, A=8'hB4 (−76), ShAmt=2, Start at t → Done only at t+3, D=8'hED (−19), Busy high t+1..t+3.
- A=8'h74, ShAmt=3 → D=8'h0E at t+4. Then with A=8'h80, ShAmt=0 → Done at t'+1, D=8'h80.
- Clamp: A=8'h81, ShAmt=12 → D=8'hFF at t+8 (c=7). Then A=8'h7F, ShAmt=15 → D=8'h00 at t'+8.
- Start pulsed with different A/ShAmt while Busy → ignored. The original result completes unchanged, and a single Done is observed.
- Back-to-back: Start held high continuously with A=8'hF0, ShAmt=1 → Done every 3 cycles, D=8'hF8 each time.
- Rst=0 asserted during SHIFT (A=8'h90, ShAmt=5, two cycles in) → next cycle D=0, Busy=0, Done=0, no Done strobe. A new Start after Rst=1 completes normally.
